// File: rtl/regfile_rename_mp.sv
// Architectural register file with rename busy/tag tracking, a single busy/tag checkpoint and flush.
// Operand reads are combinational with same-cycle rename and commit bypass.
module regfile_rename_mp #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int TAG_W = 5,
  parameter int NRD   = 2,
  parameter int NWB   = 2,
  localparam int RIDX_W = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_flush,
  input  logic                  i_ren_en,
  input  logic [RIDX_W-1:0]     i_ren_rd,
  input  logic [TAG_W-1:0]      i_ren_tag,
  input  logic [NWB-1:0]        i_wb_valid,
  input  logic [NWB*RIDX_W-1:0] i_wb_rd,
  input  logic [NWB*TAG_W-1:0]  i_wb_tag,
  input  logic [NWB*XLEN-1:0]   i_wb_data,
  input  logic                  i_ckpt_save,
  input  logic                  i_ckpt_restore,
  input  logic [NRD*RIDX_W-1:0] i_rd_id,
  output logic [NRD-1:0]        o_rd_busy,
  output logic [NRD*TAG_W-1:0]  o_rd_tag,
  output logic [NRD*XLEN-1:0]   o_rd_val
);

  logic [XLEN-1:0]   r_val   [NREG];
  logic [TAG_W-1:0]  r_tag   [NREG];
  logic [TAG_W-1:0]  r_ctag  [NREG];
  logic [NREG-1:0]   r_busy;
  logic [NREG-1:0]   r_cbusy;

  logic [XLEN-1:0]   w_val_next   [NREG];
  logic [TAG_W-1:0]  w_tag_next   [NREG];
  logic [TAG_W-1:0]  w_ctag_next  [NREG];
  logic [NREG-1:0]   w_busy_next;
  logic [NREG-1:0]   w_cbusy_next;

  logic [RIDX_W-1:0] w_wb_rd   [NWB];
  logic [TAG_W-1:0]  w_wb_tag  [NWB];
  logic [XLEN-1:0]   w_wb_data [NWB];

  genvar gi;
  for (gi = 0; gi < NWB; gi++) begin : g_wb
    assign w_wb_rd[gi]   = i_wb_rd[gi*RIDX_W +: RIDX_W];
    assign w_wb_tag[gi]  = i_wb_tag[gi*TAG_W +: TAG_W];
    assign w_wb_data[gi] = i_wb_data[gi*XLEN +: XLEN];
  end

  // Commits first (ascending port, younger wins), then flush / restore / rename+save.
  always_comb begin
    w_val_next   = r_val;
    w_tag_next   = r_tag;
    w_ctag_next  = r_ctag;
    w_busy_next  = r_busy;
    w_cbusy_next = r_cbusy;
    for (int k = 0; k < NWB; k++) begin
      if (i_wb_valid[k] && (w_wb_rd[k] != '0)) begin
        w_val_next[w_wb_rd[k]] = w_wb_data[k];
        if (w_wb_tag[k] == r_tag[w_wb_rd[k]])  w_busy_next[w_wb_rd[k]]  = 1'b0;
        if (w_wb_tag[k] == r_ctag[w_wb_rd[k]]) w_cbusy_next[w_wb_rd[k]] = 1'b0;
      end
    end
    if (i_flush) begin
      w_busy_next  = '0;
      w_cbusy_next = '0;
    end else if (i_ckpt_restore) begin
      w_busy_next = w_cbusy_next;
      w_tag_next  = r_ctag;
    end else begin
      if (i_ren_en && (i_ren_rd != '0)) begin
        w_busy_next[i_ren_rd] = 1'b1;
        w_tag_next[i_ren_rd]  = i_ren_tag;
      end
      if (i_ckpt_save) begin
        w_cbusy_next = w_busy_next;
        w_ctag_next  = w_tag_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        r_val[r]  <= '0;
        r_tag[r]  <= '0;
        r_ctag[r] <= '0;
      end
      r_busy  <= '0;
      r_cbusy <= '0;
    end else begin
      r_val   <= w_val_next;
      r_tag   <= w_tag_next;
      r_ctag  <= w_ctag_next;
      r_busy  <= w_busy_next;
      r_cbusy <= w_cbusy_next;
    end
  end

  for (gi = 0; gi < NRD; gi++) begin : g_rd
    logic [RIDX_W-1:0] w_id;
    logic              w_busy;
    logic [TAG_W-1:0]  w_tag;
    logic [XLEN-1:0]   w_val;

    assign w_id = i_rd_id[gi*RIDX_W +: RIDX_W];

    // Later matching commit ports overwrite earlier ones, so the youngest commit is forwarded.
    always_comb begin
      w_busy = r_busy[w_id];
      w_tag  = r_tag[w_id];
      w_val  = r_val[w_id];
      if (w_id == '0) begin
        w_busy = 1'b0;
        w_tag  = '0;
        w_val  = '0;
      end else if (i_ren_en && (i_ren_rd == w_id)) begin
        w_busy = 1'b1;
        w_tag  = i_ren_tag;
      end else if (r_busy[w_id]) begin
        for (int k = 0; k < NWB; k++) begin
          if (i_wb_valid[k] && (w_wb_rd[k] == w_id) && (w_wb_tag[k] == r_tag[w_id])) begin
            w_busy = 1'b0;
            w_val  = w_wb_data[k];
          end
        end
      end
    end

    assign o_rd_busy[gi]               = w_busy;
    assign o_rd_tag[gi*TAG_W +: TAG_W] = w_tag;
    assign o_rd_val[gi*XLEN +: XLEN]   = w_val;
  end

endmodule
